sram_mbist_ctrl: RTL and testbench



---
 rtl/sram_mbist_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sram_mbist_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_mbist_ctrl.sv
// March C- BIST controller driving the BIST port of a single-port SRAM macro.
// Optional MBIST_CHECKERBOARD_EN adds a second pass with a 0x55.. background.
module sram_mbist_ctrl #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output logic [2:0]           fail_elem_o,
    output logic                 bist_en_o,
    output logic                 bist_men_o,
    output logic                 bist_wen_o,
    output logic                 bist_ren_o,
    output logic [AddrWidth-1:0] bist_addr_o,
    output logic [DataWidth-1:0] bist_din_o,
    output logic [DataWidth-1:0] bist_bm_o,
    input  logic [DataWidth-1:0] bist_dout_i
);
`ifdef MBIST_CHECKERBOARD_EN
    localparam int unsigned NumPasses = 2;
`else
    localparam int unsigned NumPasses = 1;
`endif
    localparam logic                 LastPass = 1'(NumPasses - 1);
    localparam logic [AddrWidth-1:0] AddrMax  = {AddrWidth{1'b1}};
    localparam logic [DataWidth-1:0] Checker  = DataWidth'({(DataWidth + 1) / 2{2'b01}});

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q;
    logic [2:0]           elem_q, elem_d, fail_elem_q, cmp_elem_q;
    logic [AddrWidth-1:0] addr_q, addr_d, fail_addr_q, cmp_addr_q;
    logic                 phase_q, phase_d, pass_q, pass_d;
    logic                 busy_q, done_q, fail_q, en_q, men_q, wen_q, ren_q, cmp_vld_q;
    logic [DataWidth-1:0] din_q, bm_q, cmp_exp_q;
    logic                 last_op, down, addr_end, cur_rd, nxt_rd;
    logic [DataWidth-1:0] bg, bg_d, cur_exp, nxt_wdata;

    // Properties of the operation currently driven and of the one that follows it.
    assign bg        = pass_q ? Checker : '0;
    assign bg_d      = pass_d ? Checker : '0;
    assign cur_rd    = (elem_q != 3'd0) && !phase_q;
    assign cur_exp   = (elem_q == 3'd2 || elem_q == 3'd4) ? ~bg : bg;
    assign nxt_rd    = (elem_d != 3'd0) && !phase_d;
    assign nxt_wdata = (elem_d == 3'd1 || elem_d == 3'd3) ? ~bg_d : bg_d;
    assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign addr_end  = down ? (addr_q == '0) : (addr_q == AddrMax);

    // March sequencer: read/write pairs share an address, elements 3-4 run downward.
    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = 1'b0;
        pass_d  = pass_q;
        last_op = 1'b0;
        if (elem_q == 3'd0 || elem_q == 3'd5 || phase_q) begin
            if (!addr_end) begin
                addr_d = down ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
            end else if (elem_q == 3'd5) begin
                elem_d = 3'd0;
                addr_d = '0;
                if (pass_q == LastPass) begin
                    last_op = 1'b1;
                end else begin
                    pass_d = ~pass_q;
                end
            end else begin
                elem_d = elem_q + 3'd1;
                addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? AddrMax : '0;
            end
        end else begin
            phase_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            en_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            din_q       <= '0;
            bm_q        <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
        end else begin
            // Read data arrives one cycle after the read; only the first mismatch is kept.
            if (cmp_vld_q && (bist_dout_i != cmp_exp_q) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
                fail_elem_q <= cmp_elem_q;
            end
            cmp_vld_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                        en_q        <= 1'b1;
                        bm_q        <= '1;
                        elem_q      <= '0;
                        addr_q      <= '0;
                        phase_q     <= 1'b0;
                        pass_q      <= 1'b0;
                        men_q       <= 1'b1;
                        wen_q       <= 1'b1;
                        ren_q       <= 1'b0;
                        din_q       <= '0;
                    end
                end
                StRun: begin
                    cmp_vld_q  <= cur_rd;
                    cmp_exp_q  <= cur_exp;
                    cmp_addr_q <= addr_q;
                    cmp_elem_q <= elem_q;
                    if (last_op) begin
                        state_q <= StDrain;
                        men_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ren_q   <= 1'b0;
                        din_q   <= '0;
                    end else begin
                        elem_q  <= elem_d;
                        addr_q  <= addr_d;
                        phase_q <= phase_d;
                        pass_q  <= pass_d;
                        men_q   <= 1'b1;
                        wen_q   <= !nxt_rd;
                        ren_q   <= nxt_rd;
                        din_q   <= nxt_rd ? '0 : nxt_wdata;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    en_q    <= 1'b0;
                    bm_q    <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign bist_en_o   = en_q;
    assign bist_men_o  = men_q;
    assign bist_wen_o  = wen_q;
    assign bist_ren_o  = ren_q;
    assign bist_addr_o = addr_q;
    assign bist_din_o  = din_q;
    assign bist_bm_o   = bm_q;

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Directed bench for sram_mbist_ctrl with a behavioural SRAM model and injectable faults.
// Uses a 256x64 instance so each full March pass stays short.
module tb_sram_mbist_ctrl;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;
    localparam int unsigned N  = 1 << AW;
`ifdef MBIST_CHECKERBOARD_EN
    localparam int unsigned NPASS = 2;
`else
    localparam int unsigned NPASS = 1;
`endif
    localparam int EXP_OPS = 10 * N * NPASS;
    localparam int LIMIT   = EXP_OPS + 50;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          en, men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm, dout;

    int checks = 0;
    int errors = 0;
    int ops_cnt = 0;
    int fault_mode = 0;  // 0 none, 1 addr5 bit3 SA0, 2 addr N-1 bit63 SA1, 3 coupling addr 9
    logic [DW-1:0] mem [N];

    always #5 clk = ~clk;

    sram_mbist_ctrl #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .fail_addr_o(fail_addr), .fail_elem_o(fail_elem),
        .bist_en_o(en), .bist_men_o(men), .bist_wen_o(wen), .bist_ren_o(ren),
        .bist_addr_o(addr), .bist_din_o(din), .bist_bm_o(bm), .bist_dout_i(dout)
    );

    // SRAM model: bit-masked write, one-cycle read latency, faults applied on access.
    always @(posedge clk) begin
        if (en && men) begin
            if (wen) begin
                logic [DW-1:0] w;
                w = (mem[addr] & ~bm) | (din & bm);
                if (fault_mode == 3 && addr == AW'(9) && din[0] != din[1]) w[1] = din[0];
                mem[addr] <= w;
            end
            if (ren) begin
                logic [DW-1:0] r;
                r = mem[addr];
                if (fault_mode == 1 && addr == AW'(5)) r[3] = 1'b0;
                if (fault_mode == 2 && addr == AW'(N - 1)) r[63] = 1'b1;
                dout <= r;
            end
        end
        if (men) ops_cnt <= ops_cnt + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, DW'(busy), 0);
        check({tag, "_done"}, DW'(done), 0);
        check({tag, "_fail"}, DW'(fail), 0);
        check({tag, "_faddr"}, DW'(fail_addr), 0);
        check({tag, "_felem"}, DW'(fail_elem), 0);
        check({tag, "_ctl"}, DW'({en, men, wen, ren}), 0);
        check({tag, "_addr"}, DW'(addr), 0);
        check({tag, "_din"}, din, 0);
        check({tag, "_bm"}, bm, 0);
    endtask

    // Start at edge 0, then wait for done; returns the edge index where done first rose.
    task automatic run_test(input bit hold, output int done_edge);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        ops_cnt = 0;
        #1;
        if (!hold) start = 1'b0;
        check("first_op", DW'({busy, en, men, wen, ren, done}), DW'(6'b111100));
        check("first_addr_din", DW'(addr) | din, 0);
        check("first_bm", bm, '1);
        done_edge = -1;
        for (int e = 1; e <= LIMIT; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_edge = e;
                break;
            end
        end
        start = 1'b0;
        check("done_edge", DW'(done_edge), DW'(EXP_OPS + 1));
        check("op_count", DW'(ops_cnt), DW'(EXP_OPS));
        check("post_busy_en", DW'({busy, en}), 0);
    endtask

    initial begin
        int de;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        fault_mode = 0;
        run_test(1'b0, de);
        check("clean_fail", DW'(fail), 0);
        check("clean_bm_off", bm, 0);

        fault_mode = 1;
        run_test(1'b0, de);
        check("sa0_fail", DW'(fail), 1);
        check("sa0_addr", DW'(fail_addr), 5);
        check("sa0_elem", DW'(fail_elem), 2);

        fault_mode = 2;
        run_test(1'b0, de);
        check("sa1_fail", DW'(fail), 1);
        check("sa1_addr", DW'(fail_addr), DW'(N - 1));
        check("sa1_elem", DW'(fail_elem), 1);

        // start held through the whole run: no restart, prior capture cleared
        fault_mode = 0;
        run_test(1'b1, de);
        check("hold_fail", DW'(fail), 0);
        check("hold_faddr", DW'(fail_addr), 0);

        // reset in the middle of a faulty run
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        check("mid_busy", DW'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        run_test(1'b0, de);
        check("after_rst_fail", DW'(fail), 0);

        // coupling fault only visible with a checkerboard background
        fault_mode = 3;
        run_test(1'b0, de);
        check("cpl_fail", DW'(fail), DW'(NPASS == 2));
        check("cpl_addr", DW'(fail_addr), (NPASS == 2) ? 64'd9 : 64'd0);
        check("cpl_elem", DW'(fail_elem), (NPASS == 2) ? 64'd1 : 64'd0);
        check("cpl_done_held", DW'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
